// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order write-back FIFO feeding the register file write port, with bypassed read operands.
module regfile_wb_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              in_rd,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    hold,
  output logic                    we,
  output logic [4:0]              rd,
  output logic [DATA_WIDTH-1:0]   data,
  input  logic [4:0]              rs,
  input  logic [4:0]              rt,
  input  logic [DATA_WIDTH-1:0]   a_rf,
  input  logic [DATA_WIDTH-1:0]   b_rf,
  output logic [DATA_WIDTH-1:0]   a,
  output logic [DATA_WIDTH-1:0]   b,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [4:0]            ent_rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  we_q;
  logic [4:0]            rd_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  push, pop;
  assign empty    = count_q == '0;
  assign full     = count_q == CW'(DEPTH);
  assign in_ready = !full;
  assign count    = count_q;
  assign we       = we_q;
  assign rd       = rd_q;
  assign data     = data_q;
  // writes to r0 are accepted by the handshake but never queued
  assign push     = in_valid && in_ready && (in_rd != 5'd0);
  assign pop      = !empty && !hold;
  assign count_d  = count_q + CW'(push) - CW'(pop);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
    end else begin
      count_q <= count_d;
      we_q    <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        rd_q     <= ent_rd_q[rd_ptr_q];
        data_q   <= ent_data_q[rd_ptr_q];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd_q[wr_ptr_q]   <= in_rd;
      ent_data_q[wr_ptr_q] <= in_data;
    end
  end
  // scan oldest to youngest so the youngest matching queued entry wins over the output stage
  always_comb begin
    a = (we_q && rd_q == rs) ? data_q : a_rf;
    b = (we_q && rd_q == rt) ? data_q : b_rf;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if (ent_rd_q[rd_ptr_q + PW'(i)] == rs) a = ent_data_q[rd_ptr_q + PW'(i)];
        if (ent_rd_q[rd_ptr_q + PW'(i)] == rt) b = ent_data_q[rd_ptr_q + PW'(i)];
      end
    end
    if (rs == 5'd0) a = '0;
    if (rt == 5'd0) b = '0;
  end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: table-driven vectors plus directed sequences for bypass, r0 and reset corners.
module tb_regfile_wb_queue;
  logic        clk, rst, in_valid, in_ready, hold, we, full, empty;
  logic [4:0]  in_rd, rd, rs, rt;
  logic [31:0] in_data, data, a_rf, b_rf, a, b;
  logic [2:0]  count;
  int checks = 0;
  int failures = 0;

  regfile_wb_queue #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_data(in_data), .hold(hold), .we(we), .rd(rd), .data(data), .rs(rs), .rt(rt),
    .a_rf(a_rf), .b_rf(b_rf), .a(a), .b(b), .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  ird;
    logic [31:0] idat;
    logic        h;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] dat;
    logic [2:0]  cnt;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t vec [13];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec[0]  = '{1'b1, 5'd1, 32'd2001, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0,    3'd1, 32'd2001, 32'd22};
    vec[1]  = '{1'b0, 5'd0, 32'd0,    1'b0, 5'd1, 5'd2, 1'b1, 5'd1, 32'd2001, 3'd0, 32'd2001, 32'd22};
    vec[2]  = '{1'b0, 5'd0, 32'd0,    1'b0, 5'd1, 5'd2, 1'b0, 5'd1, 32'd2001, 3'd0, 32'd11,   32'd22};
    vec[3]  = '{1'b1, 5'd1, 32'd2001, 1'b1, 5'd1, 5'd2, 1'b0, 5'd1, 32'd2001, 3'd1, 32'd2001, 32'd22};
    vec[4]  = '{1'b1, 5'd2, 32'd4001, 1'b1, 5'd1, 5'd2, 1'b0, 5'd1, 32'd2001, 3'd2, 32'd2001, 32'd4001};
    vec[5]  = '{1'b1, 5'd6, 32'd5001, 1'b1, 5'd6, 5'd2, 1'b0, 5'd1, 32'd2001, 3'd3, 32'd5001, 32'd4001};
    vec[6]  = '{1'b1, 5'd8, 32'd3001, 1'b1, 5'd8, 5'd6, 1'b0, 5'd1, 32'd2001, 3'd4, 32'd3001, 32'd5001};
    vec[7]  = '{1'b1, 5'd9, 32'd7777, 1'b1, 5'd9, 5'd8, 1'b0, 5'd1, 32'd2001, 3'd4, 32'd11,   32'd3001};
    vec[8]  = '{1'b1, 5'd9, 32'd7777, 1'b0, 5'd9, 5'd1, 1'b1, 5'd1, 32'd2001, 3'd3, 32'd11,   32'd2001};
    vec[9]  = '{1'b0, 5'd0, 32'd0,    1'b0, 5'd9, 5'd2, 1'b1, 5'd2, 32'd4001, 3'd2, 32'd11,   32'd4001};
    vec[10] = '{1'b0, 5'd0, 32'd0,    1'b0, 5'd9, 5'd6, 1'b1, 5'd6, 32'd5001, 3'd1, 32'd11,   32'd5001};
    vec[11] = '{1'b0, 5'd0, 32'd0,    1'b0, 5'd9, 5'd8, 1'b1, 5'd8, 32'd3001, 3'd0, 32'd11,   32'd3001};
    vec[12] = '{1'b0, 5'd0, 32'd0,    1'b0, 5'd9, 5'd8, 1'b0, 5'd8, 32'd3001, 3'd0, 32'd11,   32'd22};

    rst = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0; hold = 1'b0;
    rs = '0; rt = '0; a_rf = 32'd11; b_rf = 32'd22;
    #12;
    chk("rst_we", we, 0);
    chk("rst_rd", rd, 0);
    chk("rst_data", data, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", in_ready, 1);
    tick;
    rst = 1'b1;
    tick;

    // single write, then fill to full with a refused fifth push, then drain in order
    for (int i = 0; i < 13; i++) begin
      in_valid = vec[i].v; in_rd = vec[i].ird; in_data = vec[i].idat; hold = vec[i].h;
      rs = vec[i].rs; rt = vec[i].rt;
      tick;
      chk($sformatf("v%0d_we", i), we, vec[i].we);
      chk($sformatf("v%0d_rd", i), rd, vec[i].rd);
      chk($sformatf("v%0d_data", i), data, vec[i].dat);
      chk($sformatf("v%0d_count", i), count, vec[i].cnt);
      chk($sformatf("v%0d_full", i), full, vec[i].cnt == 3'd4);
      chk($sformatf("v%0d_ready", i), in_ready, vec[i].cnt != 3'd4);
      chk($sformatf("v%0d_empty", i), empty, vec[i].cnt == 3'd0);
      chk($sformatf("v%0d_a", i), a, vec[i].a);
      chk($sformatf("v%0d_b", i), b, vec[i].b);
    end

    // bypass: youngest queued entry wins, then output-stage forwarding
    hold = 1'b1; in_valid = 1'b1; in_rd = 5'd6; in_data = 32'd5001;
    tick;
    in_data = 32'd6001;
    tick;
    in_valid = 1'b0; a_rf = 32'd0; b_rf = 32'd4001; rs = 5'd6; rt = 5'd2;
    #1;
    chk("byp_count", count, 2);
    chk("byp_young_a", a, 6001);
    chk("byp_nomatch_b", b, 4001);
    rs = 5'd0; a_rf = 32'd99;
    #1;
    chk("byp_r0_a", a, 0);
    rs = 5'd6; a_rf = 32'd55; hold = 1'b0;
    tick;
    chk("byp_pop1_we", we, 1);
    chk("byp_pop1_data", data, 5001);
    chk("byp_pop1_a", a, 6001);
    tick;
    chk("byp_pop2_we", we, 1);
    chk("byp_pop2_data", data, 6001);
    chk("byp_out_a", a, 6001);
    tick;
    chk("byp_idle_we", we, 0);
    chk("byp_rf_a", a, 55);

    // register zero is accepted but never stored or written
    in_valid = 1'b1; in_rd = 5'd0; in_data = 32'd1234; rs = 5'd0; a_rf = 32'd77;
    tick;
    chk("r0_count", count, 0);
    chk("r0_ready", in_ready, 1);
    chk("r0_we0", we, 0);
    in_valid = 1'b0;
    tick;
    chk("r0_we1", we, 0);
    chk("r0_a", a, 0);

    // reset mid-burst while a write is on the output and in_valid is high
    hold = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_rd = 5'(3 + i); in_data = 32'(1 + i);
      tick;
    end
    chk("mid_count3", count, 3);
    hold = 1'b0; in_valid = 1'b0;
    tick;
    chk("mid_we", we, 1);
    chk("mid_rd", rd, 3);
    in_valid = 1'b1; in_rd = 5'd10; in_data = 32'd4242; hold = 1'b1;
    rst = 1'b0;
    #1;
    chk("arst_we", we, 0);
    chk("arst_rd", rd, 0);
    chk("arst_data", data, 0);
    chk("arst_count", count, 0);
    chk("arst_ready", in_ready, 1);
    tick;
    chk("arst_nopush", count, 0);
    rst = 1'b1; in_valid = 1'b0; hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("post_rst%0d_we", i), we, 0);
      chk($sformatf("post_rst%0d_count", i), count, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
